// File: rtl/mux_sched_pkg.sv
// Purpose: shared types and defaults for the mux select scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_sched_pkg;

    localparam int DEFAULT_N        = 16;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Purpose: rotating-priority search, first set req bit at or after ptr+1 (mod N).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is recomputed every cycle from req and ptr.
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the last owner; the search starts just above it
//   found - high when any req bit is set
//   idx   - index of the picked requester (0 when found is low)
module rr_pick #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Walk offsets from N down to 1 so the smallest offset that hits wins.
    // N is a power of two, so truncating ptr+offset to SEL_W bits is the
    // modulo-N wrap; offset N lands back on ptr itself, which makes the
    // current owner the lowest-priority candidate.
    always_comb begin
        logic [SEL_W-1:0] j;
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N; i >= 1; i--) begin
            j = ptr + SEL_W'(i);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Purpose: round-robin owner selection driving the select lines of a shared N:1 mux.
// Latency: 1 cycle from req sampled high to gnt/sel; 1 cycle from owner release to handover.
// Backpressure: owner holds until it drops req; other requesters simply wait (no queueing).
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   req   - request vector
//   sel   - mux select, index of current owner (holds last owner while idle)
//   gnt   - one-hot grant, zero when no owner
//   valid - high while a grant is active
//
// Build option: define MUX_SCHED_TIMEOUT_EN to add a hold counter that
// preempts an owner after MAX_HOLD cycles when someone else is waiting.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int SEL_W    = $clog2(N),
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    // Elaboration-time parameter sanity checks.
    if ((N < 2) || (N > 64) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("mux_sel_scheduler: N must be a power of two in 2..64");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("mux_sel_scheduler: MAX_HOLD must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic             owner_req;
    logic             other_req;
    logic             preempt;
    logic             do_grant;
    logic             do_idle;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // sel always names the current owner while in GRANT.
    assign owner_req = req[sel];
    assign other_req = |(req & ~gnt);

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             hold_reach;

    // hold_cnt counts completed grant cycles after the granting edge, so the
    // edge at which it would reach MAX_HOLD ends exactly MAX_HOLD owned cycles.
    assign hold_reach = (int'(hold_cnt) + 1) >= MAX_HOLD;
    assign preempt    = (state == GRANT) && owner_req && hold_reach && other_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (do_grant) begin
            hold_cnt <= '0;
        end else if ((state == GRANT) && (int'(hold_cnt) < MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (!owner_req && !found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decisions. When the owner has dropped req, any hit from the
    // picker is necessarily a different requester; on preemption the owner
    // is searched last, so the pick is also someone else.
    always_comb begin
        do_grant = 1'b0;
        do_idle  = 1'b0;
        case (state)
            IDLE:    do_grant = found;
            GRANT: begin
                do_grant = (!owner_req && found) || preempt;
                do_idle  = !owner_req && !found;
            end
            default: ;
        endcase
    end

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= SEL_W'(N - 1);
            sel   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else if (do_grant) begin
            ptr   <= pick;
            sel   <= pick;
            gnt   <= N'(1) << pick;
            valid <= 1'b1;
        end else if (do_idle) begin
            gnt   <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Purpose: self-checking bench for mux_sel_scheduler (default build, N=16).
// Latency: expects outputs one edge after req is applied.
// Backpressure: n/a.
module tb_mux_sel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_sel_scheduler #(
        .N        (16),
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid)
    );

    typedef struct {
        logic [15:0] req;
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        valid;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected grant is derived from the expected owner index.
    function automatic void add(input logic [15:0] r, input int s, input logic v, input int reps);
        vec_t e;
        e.req   = r;
        e.sel   = 4'(s);
        e.valid = v;
        e.gnt   = v ? (16'h0001 << s) : 16'h0000;
        for (int k = 0; k < reps; k++) vecs.push_back(e);
    endfunction

    task automatic check_out(input string tag, input vec_t e);
        chk({tag, ".sel"},   32'(sel),   32'(e.sel));
        chk({tag, ".gnt"},   32'(gnt),   32'(e.gnt));
        chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
        chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    // Drive each vector at a falling edge, score it one rising edge later.
    task automatic run_vecs(input string tag);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req = vecs[i].req;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out($sformatf("%s[%0d]", tag, i), e);
        end
        vecs.delete();
    endtask

    task automatic check_reset(input string tag);
        vec_t e;
        e.req = '0; e.sel = 4'd0; e.gnt = 16'h0; e.valid = 1'b0;
        check_out(tag, e);
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        req = 16'h0000;
        #1;
        check_reset("reset0");
        @(negedge clk);
        rst = 1'b0;

        // Idle, single grant, release keeps sel.
        add(16'h0000, 0, 1'b0, 5);
        add(16'h0020, 5, 1'b1, 1);
        add(16'h0000, 5, 1'b0, 1);
        run_vecs("p1");

        // Async reset while idle with sel=5 clears sel without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("reset1");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back handovers, wrap, lone requester, transient requests,
        // owner holding indefinitely with a competing request (no timeout build).
        add(16'h1121,  0, 1'b1, 2);
        add(16'h1120,  5, 1'b1, 2);
        add(16'h1100,  8, 1'b1, 2);
        add(16'h1000, 12, 1'b1, 2);
        add(16'h0121,  0, 1'b1, 1);
        add(16'h0000,  0, 1'b0, 1);
        add(16'h8000, 15, 1'b1, 1);
        add(16'h0001,  0, 1'b1, 1);
        add(16'h0000,  0, 1'b0, 1);
        add(16'h0004,  2, 1'b1, 1);
        add(16'h0000,  2, 1'b0, 1);
        add(16'h0004,  2, 1'b1, 1);
        add(16'h0000,  2, 1'b0, 1);
        add(16'h0010,  4, 1'b1, 1);
        add(16'h0030,  4, 1'b1, 1);
        add(16'h0010,  4, 1'b1, 1);
        add(16'h0000,  4, 1'b0, 2);
        add(16'h0009,  0, 1'b1, 12);
        add(16'h0000,  0, 1'b0, 1);
        run_vecs("p2");

        // Reset asserted mid-grant, then first pick after reset starts at 0.
        @(negedge clk);
        req = 16'h1000;
        @(posedge clk);
        #1;
        e.req = 16'h1000; e.sel = 4'd12; e.gnt = 16'h1000; e.valid = 1'b1;
        check_out("pre_rst", e);
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        req = 16'h1001;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        e.req = 16'h1001; e.sel = 4'd0; e.gnt = 16'h0001; e.valid = 1'b1;
        check_out("post_rst", e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
